// File: rtl/ram_arbiter_if.sv
// Bundle between two RAM requesters (fetch port A, load/store port B), the arbiter and a
// single-port synchronous RAM.
interface ram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_gnt;
    logic                  a_done;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_done;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic [ADDR_WIDTH-1:0] ram_read_address;
    logic [ADDR_WIDTH-1:0] ram_write_address;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    logic                  busy;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_dout,
        output a_gnt, a_done, a_rdata, b_gnt, b_done, b_rdata,
               ram_read_address, ram_write_address, ram_write, ram_din, busy
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_dout,
        input  a_gnt, a_done, a_rdata, b_gnt, b_done, b_rdata,
               ram_read_address, ram_write_address, ram_write, ram_din, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between a read-only fetch port (A) and a
// load/store port (B). Writes complete in 2 cycles, reads in 3 (RAM has 1-cycle read latency).
module ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last_b;
    logic                  r_port_b;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_a_done;
    logic                  r_b_done;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic                  w_a_win;
    logic                  w_b_win;
    logic                  w_finish;

    // Next state and arbitration; a conflict goes to the port not granted last.
    always_comb begin
        w_next  = r_state;
        w_a_win = 1'b0;
        w_b_win = 1'b0;
        case (r_state)
            IDLE: begin
                w_a_win = bus.a_req & (~bus.b_req | r_last_b);
                w_b_win = bus.b_req & ~w_a_win;
                if (w_a_win | w_b_win) begin
                    w_next = ACCESS;
                end
            end
            ACCESS:  w_next = r_we ? IDLE : DATA;
            DATA:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_finish = ((r_state == ACCESS) && r_we) || (r_state == DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture on the grant edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_b <= 1'b1;
            r_port_b <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_a_win | w_b_win) begin
            r_last_b <= w_b_win;
            r_port_b <= w_b_win;
            r_we     <= w_b_win & bus.b_we;
            r_addr   <= w_b_win ? bus.b_addr : bus.a_addr;
            r_wdata  <= w_b_win ? bus.b_wdata : DATA_WIDTH'(0);
        end
    end

    // Completion pulse and per-port read data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_done <= w_finish & ~r_port_b;
            r_b_done <= w_finish & r_port_b;
            if (r_state == DATA) begin
                if (r_port_b) begin
                    r_b_rdata <= bus.ram_dout;
                end else begin
                    r_a_rdata <= bus.ram_dout;
                end
            end
        end
    end

    assign bus.a_gnt             = w_a_win & reset_n;
    assign bus.b_gnt             = w_b_win & reset_n;
    assign bus.a_done            = r_a_done;
    assign bus.b_done            = r_b_done;
    assign bus.a_rdata           = r_a_rdata;
    assign bus.b_rdata           = r_b_rdata;
    assign bus.ram_read_address  = r_addr;
    assign bus.ram_write_address = r_addr;
    assign bus.ram_din           = r_wdata;
    assign bus.ram_write         = (r_state == ACCESS) & r_we;
    assign bus.busy              = (r_state != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_arbiter;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    ram_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    ram_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // RAM model: untouched locations return fixed preload contents.
    logic [15:0] mem [256];
    bit          written [256];

    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'h01:   return 16'h1111;
            8'h02:   return 16'h2222;
            8'h05:   return 16'h1234;
            8'h20:   return 16'h0BAD;
            default: return 16'(a) * 16'd3;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.ram_write) begin
            mem[bus.ram_write_address]     <= bus.ram_din;
            written[bus.ram_write_address] <= 1'b1;
        end
        bus.ram_dout <= written[bus.ram_read_address] ? mem[bus.ram_read_address]
                                                      : init_val(bus.ram_read_address);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nxt();
        nxt();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.a_req = 1'b1; bus.a_addr = 8'h00;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h00; bus.b_wdata = 16'h0;

        // Reset state, grants forced low despite requests
        mid();
        chk("rst_a_gnt", 32'(bus.a_gnt), 0);
        chk("rst_b_gnt", 32'(bus.b_gnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ram_write", 32'(bus.ram_write), 0);
        chk("rst_done", {30'b0, bus.a_done, bus.b_done}, 0);
        chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
        chk("rst_addr", {16'(bus.ram_read_address), 8'(bus.ram_write_address)}, 0);
        chk("rst_din", 32'(bus.ram_din), 0);

        // A alone reads 0x05
        nxt();
        reset_n = 1'b1;
        bus.b_req = 1'b0; bus.a_addr = 8'h05;
        mid();
        chk("t1_a_gnt", 32'(bus.a_gnt), 1);
        chk("t1_b_gnt", 32'(bus.b_gnt), 0);
        nxt();
        bus.a_req = 1'b0;
        mid();
        chk("t1_raddr", 32'(bus.ram_read_address), 32'h05);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_nowrite", 32'(bus.ram_write), 0);
        nxt(); mid();
        chk("t1_nodone_c2", 32'(bus.a_done), 0);
        nxt(); mid();
        chk("t1_a_done", 32'(bus.a_done), 1);
        chk("t1_a_rdata", 32'(bus.a_rdata), 32'h1234);
        chk("t1_idle", 32'(bus.busy), 0);

        // B alone writes 0xBEEF to 0x10, then A reads it back
        nxt();
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h10; bus.b_wdata = 16'hBEEF;
        mid();
        chk("t2_b_gnt", 32'(bus.b_gnt), 1);
        nxt();
        bus.b_req = 1'b0;
        mid();
        chk("t2_ram_write", 32'(bus.ram_write), 1);
        chk("t2_waddr", 32'(bus.ram_write_address), 32'h10);
        chk("t2_din", 32'(bus.ram_din), 32'hBEEF);
        nxt();
        bus.a_req = 1'b1; bus.a_addr = 8'h10;
        mid();
        chk("t2_b_done", 32'(bus.b_done), 1);
        chk("t2_write_low", 32'(bus.ram_write), 0);
        chk("t2_b_rdata", 32'(bus.b_rdata), 0);
        chk("t2_a_gnt_in_done", 32'(bus.a_gnt), 1);
        nxt();
        bus.a_req = 1'b0;
        nxt();
        nxt(); mid();
        chk("t2_a_done", 32'(bus.a_done), 1);
        chk("t2_readback", 32'(bus.a_rdata), 32'hBEEF);

        // B write while A requests: A ignored until IDLE, granted in B's done cycle
        nxt();
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h30; bus.b_wdata = 16'h5555;
        mid();
        chk("t3_b_gnt", 32'(bus.b_gnt), 1);
        nxt();
        bus.b_req = 1'b0; bus.a_req = 1'b1; bus.a_addr = 8'h30;
        mid();
        chk("t3_a_ignored", 32'(bus.a_gnt), 0);
        nxt(); mid();
        chk("t3_b_done", 32'(bus.b_done), 1);
        chk("t3_a_gnt", 32'(bus.a_gnt), 1);
        chk("t3_b_rdata_kept", 32'(bus.b_rdata), 0);
        nxt();
        bus.a_req = 1'b0;
        nxt();
        nxt(); mid();
        chk("t3_a_rdata", 32'(bus.a_rdata), 32'h5555);

        // Back-to-back B reads of 0x01 then 0x02
        nxt();
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h01;
        mid();
        chk("t4_gnt0", 32'(bus.b_gnt), 1);
        nxt();
        bus.b_addr = 8'h02;
        mid();
        chk("t4_no_gnt", 32'(bus.b_gnt), 0);
        nxt();
        nxt(); mid();
        chk("t4_done1", 32'(bus.b_done), 1);
        chk("t4_rdata1", 32'(bus.b_rdata), 32'h1111);
        chk("t4_gnt1", 32'(bus.b_gnt), 1);
        nxt();
        bus.b_req = 1'b0;
        mid();
        chk("t4_done_pulse", 32'(bus.b_done), 0);
        nxt();
        nxt(); mid();
        chk("t4_done2", 32'(bus.b_done), 1);
        chk("t4_rdata2", 32'(bus.b_rdata), 32'h2222);
        chk("t4_a_rdata_kept", 32'(bus.a_rdata), 32'h5555);

        // Reset during the ACCESS cycle of a B write to 0x20
        nxt();
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h20; bus.b_wdata = 16'hDEAD;
        mid();
        chk("t5_b_gnt", 32'(bus.b_gnt), 1);
        nxt();
        bus.b_req = 1'b0;
        mid();
        chk("t5_write_before", 32'(bus.ram_write), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_write_dropped", 32'(bus.ram_write), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_b_rdata_clr", 32'(bus.b_rdata), 0);
        nxt();
        reset_n = 1'b1;
        bus.a_req = 1'b1; bus.a_addr = 8'h20;
        mid();
        chk("t5_first_gnt", 32'(bus.a_gnt), 1);
        chk("t5_no_b_done", 32'(bus.b_done), 0);
        nxt();
        bus.a_req = 1'b0;
        mid();
        chk("t5_no_b_done2", 32'(bus.b_done), 0);
        nxt();
        nxt(); mid();
        chk("t5_loc_unchanged", 32'(bus.a_rdata), 32'h0BAD);

        // Both requesting continuously after reset: A, B, A, B every 3 cycles
        nxt();
        do_reset();
        bus.a_req = 1'b1; bus.a_addr = 8'h01;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h02;
        for (int c = 0; c < 12; c++) begin
            mid();
            chk($sformatf("rr_a_gnt_c%0d", c), 32'(bus.a_gnt),
                ((c % 3) == 0 && ((c / 3) % 2) == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_b_gnt_c%0d", c), 32'(bus.b_gnt),
                ((c % 3) == 0 && ((c / 3) % 2) == 1) ? 32'd1 : 32'd0);
            nxt();
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        mid();
        chk("rr_b_done", 32'(bus.b_done), 1);
        chk("rr_b_rdata", 32'(bus.b_rdata), 32'h2222);
        chk("rr_a_rdata", 32'(bus.a_rdata), 32'h1111);
        chk("rr_no_gnt", {30'b0, bus.a_gnt, bus.b_gnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the RAM address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 a_req  in  1  SHALL be the port A (fetch, read-only) request; a_addr  in  ADDR_WIDTH is its address.
REQ-006 a_gnt  out  1  SHALL be the port A grant; a_done  out  1 and a_rdata  out  DATA_WIDTH are its completion pulse and read data.
REQ-007 b_req  in  1, b_we  in  1, b_addr  in  ADDR_WIDTH and b_wdata  in  DATA_WIDTH SHALL be the port B (load/store) request, write enable, address and write data.
REQ-008 b_gnt  out  1, b_done  out  1 and b_rdata  out  DATA_WIDTH SHALL be the port B grant, completion pulse and read data.
REQ-009 ram_read_address  out  ADDR_WIDTH, ram_write_address  out  ADDR_WIDTH, ram_write  out  1, ram_din  out  DATA_WIDTH SHALL drive the RAM.
REQ-010 ram_dout  in  DATA_WIDTH SHALL be the RAM read data, registered inside the RAM with 1-cycle latency.
REQ-011 busy  out  1 SHALL be high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACCESS, DATA.
REQ-013 In IDLE, a_gnt/b_gnt SHALL be combinational: at most one high, only for the arbitration winner, both forced low while reset_n is low.
REQ-014 With a single request, that port SHALL win; with both requesting, the port not granted most recently SHALL win (round-robin).
REQ-015 On the edge ending a grant cycle, the block SHALL latch the winner's address, write enable (0 for port A), write data and port ID, and SHALL enter ACCESS.
REQ-016 A requester SHALL hold req and its request fields stable until it samples gnt high; the arbiter SHALL ignore req outside IDLE.
REQ-017 In ACCESS, ram_read_address and ram_write_address SHALL both equal the latched address, ram_din the latched data, and ram_write the latched write enable.
REQ-018 ram_write SHALL be high only in ACCESS with a latched write; it SHALL be low in every other state.
REQ-019 A write in ACCESS SHALL go to IDLE and pulse the owning port's done for exactly the next cycle; write latency is 2 cycles from grant cycle to done.
REQ-020 A read in ACCESS SHALL go to DATA; on the edge ending DATA, ram_dout SHALL be registered into the owning port's rdata, done SHALL pulse for one cycle, and the state SHALL go to IDLE.
REQ-021 Read latency SHALL be 3 cycles from grant cycle to done; the data SHALL be valid in the done cycle.
REQ-022 a_rdata/b_rdata SHALL hold their value until that port's next read completes; a write or the other port's read SHALL NOT change them.
REQ-023 A new grant SHALL be possible in the same cycle a done pulse is high (the state is IDLE then).
REQ-024 Sustained throughput SHALL be one write per 2 cycles or one read per 3 cycles.
REQ-025 Outside ACCESS, the RAM address and din outputs SHALL hold their last latched values.

Reset
REQ-026 While reset_n is low: state=IDLE, last-winner=B (A wins the first conflict), a_gnt=b_gnt=0, a_done=b_done=0, ram_write=0, busy=0, a_rdata=b_rdata=0, RAM address/din outputs=0.
REQ-027 Reset asserted mid-operation SHALL deassert ram_write immediately (asynchronously); the transaction SHALL be dropped with no done pulse.
REQ-028 After reset_n rises, the first grant SHALL occur in the first cycle with a request present.

Verification
REQ-029 Port A alone reads addr 0x05 (RAM holds 0x1234) -> a_gnt cycle 0, ram_read_address=0x05 cycle 1, a_done=1 and a_rdata=0x1234 cycle 3.
REQ-030 Port B alone writes 0xBEEF to 0x10 -> ram_write=1, ram_write_address=0x10, ram_din=0xBEEF cycle 1; b_done cycle 2; a later A read of 0x10 returns 0xBEEF.
REQ-031 a_req and b_req held continuously after reset -> grants alternate A, B, A, B; no two consecutive grants to the same port.
REQ-032 B write done in the same cycle a_req is high -> a_gnt asserted in that done cycle; b_rdata unchanged.
REQ-033 reset_n pulsed low in the ACCESS cycle of a B write to 0x20 -> ram_write falls immediately, no b_done, location 0x20 unchanged, busy=0.
REQ-034 Back-to-back B reads of 0x01 then 0x02 -> two b_done pulses 3 cycles apart, with b_rdata matching each location in turn.
